// File: rtl/connect4_turn_controller.sv
// connect4_turn_controller
//   Game-flow sequencer for a 4x4 Connect4 board. Applies gravity to a column
//   choice, keeps a shadow copy of the board, and ends the game on a win or draw.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous, active-high; clears all state
//   start           pulse: INIT -> play, or END -> INIT
//   col_valid       pulse: a column choice is presented on col_sel
//   col_sel         chosen column 0-3
//   state           00 GAME_INIT, 01 P1_TURN, 10 P2_TURN, 11 END_GAME
//   column_position target cell row*4+col (row 0 = bottom); NO_SEL when idle
//   current_player  0 = P1, 1 = P2
//   winner          00 none, 01 P1, 10 P2, 11 draw
//   invalid_move    one-cycle pulse when a move into a full column is rejected
//   move_count      number of filled cells, 0-16
//
// Timing: a col_valid sampled in cycle N gives column_position in cycle N+1
// (PLACE). The line check is evaluated in PLACE on the board including the new
// piece, so state/winner/current_player already show the result in cycle N+2
// (CHECK). CHECK then only steers the FSM to END or back to WAIT.
module connect4_turn_controller #(
    parameter logic [4:0] NO_SEL = 5'b11111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       col_valid,
    input  logic [1:0] col_sel,
    output logic [1:0] state,
    output logic [4:0] column_position,
    output logic       current_player,
    output logic [1:0] winner,
    output logic       invalid_move,
    output logic [4:0] move_count
);

    typedef enum logic [2:0] {StInit, StWait, StPlace, StCheck, StEnd} fsm_e;

    localparam logic [1:0] TurnInit = 2'b00;
    localparam logic [1:0] TurnP1   = 2'b01;
    localparam logic [1:0] TurnP2   = 2'b10;
    localparam logic [1:0] TurnEnd  = 2'b11;

    // 10 winning lines: 4 rows, 4 columns, diagonal, anti-diagonal.
    localparam logic [159:0] LineMasks = {
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    fsm_e        fsm_q, fsm_d;
    logic [15:0] filled_q, filled_d;
    logic [15:0] owner_q, owner_d;
    logic [3:0]  target_q, target_d;
    logic [1:0]  state_q, state_d;
    logic [4:0]  column_position_q, column_position_d;
    logic        current_player_q, current_player_d;
    logic [1:0]  winner_q, winner_d;
    logic        invalid_move_q, invalid_move_d;
    logic [4:0]  move_count_q, move_count_d;

    logic [2:0]  col_height;
    logic        col_full;
    logic [15:0] place_mask;
    logic [15:0] filled_next;
    logic [15:0] owner_next;
    logic [15:0] mover_cells;
    logic        mover_win;

    // Gravity: pieces stack contiguously, so the fill count is the next free row.
    always_comb begin
        col_height = 3'($countones(filled_q & (16'h1111 << col_sel)));
        col_full   = col_height[2];
    end

    // Board as it will be once the PLACE cycle commits the latched target.
    always_comb begin
        place_mask  = 16'h0001 << target_q;
        filled_next = filled_q | place_mask;
        owner_next  = current_player_q ? (owner_q | place_mask) : (owner_q & ~place_mask);
        mover_cells = filled_next & (current_player_q ? owner_next : ~owner_next);
        mover_win   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ((mover_cells & LineMasks[i*16 +: 16]) == LineMasks[i*16 +: 16]) begin
                mover_win = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q <= StInit;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StInit:  if (start) fsm_d = StWait;
            StWait:  if (col_valid && !col_full) fsm_d = StPlace;
            StPlace: fsm_d = StCheck;
            StCheck: fsm_d = (winner_q != 2'b00) ? StEnd : StWait;
            StEnd:   if (start) fsm_d = StInit;
            default: fsm_d = StInit;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        filled_d          = filled_q;
        owner_d           = owner_q;
        target_d          = target_q;
        state_d           = state_q;
        column_position_d = NO_SEL;
        current_player_d  = current_player_q;
        winner_d          = winner_q;
        invalid_move_d    = 1'b0;
        move_count_d      = move_count_q;

        unique case (fsm_q)
            StInit: begin
                filled_d         = '0;
                owner_d          = '0;
                winner_d         = 2'b00;
                move_count_d     = '0;
                current_player_d = 1'b0;
                state_d          = start ? TurnP1 : TurnInit;
            end
            StWait: begin
                if (col_valid) begin
                    if (col_full) begin
                        invalid_move_d = 1'b1;
                    end else begin
                        target_d          = {col_height[1:0], col_sel};
                        column_position_d = {1'b0, col_height[1:0], col_sel};
                    end
                end
            end
            StPlace: begin
                filled_d     = filled_next;
                owner_d      = owner_next;
                move_count_d = move_count_q + 5'd1;
                if (mover_win) begin
                    winner_d = current_player_q ? 2'b10 : 2'b01;
                    state_d  = TurnEnd;
                end else if (move_count_q == 5'd15) begin
                    // This placement fills the 16th cell.
                    winner_d = 2'b11;
                    state_d  = TurnEnd;
                end else begin
                    current_player_d = ~current_player_q;
                    state_d          = current_player_q ? TurnP1 : TurnP2;
                end
            end
            StCheck: begin
            end
            StEnd: begin
                if (start) begin
                    filled_d         = '0;
                    owner_d          = '0;
                    winner_d         = 2'b00;
                    move_count_d     = '0;
                    current_player_d = 1'b0;
                    state_d          = TurnInit;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filled_q          <= '0;
            owner_q           <= '0;
            target_q          <= '0;
            state_q           <= TurnInit;
            column_position_q <= NO_SEL;
            current_player_q  <= 1'b0;
            winner_q          <= 2'b00;
            invalid_move_q    <= 1'b0;
            move_count_q      <= '0;
        end else begin
            filled_q          <= filled_d;
            owner_q           <= owner_d;
            target_q          <= target_d;
            state_q           <= state_d;
            column_position_q <= column_position_d;
            current_player_q  <= current_player_d;
            winner_q          <= winner_d;
            invalid_move_q    <= invalid_move_d;
            move_count_q      <= move_count_d;
        end
    end

    assign state           = state_q;
    assign column_position = column_position_q;
    assign current_player  = current_player_q;
    assign winner          = winner_q;
    assign invalid_move    = invalid_move_q;
    assign move_count      = move_count_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Scoreboard bench for connect4_turn_controller: a board-level game model
// predicts each move's outcome, a monitor checks DUT events against it.
module tb_connect4_turn_controller;

    localparam logic [4:0] NO_SEL = 5'b11111;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       col_valid;
    logic [1:0] col_sel;
    logic [1:0] state;
    logic [4:0] column_position;
    logic       current_player;
    logic [1:0] winner;
    logic       invalid_move;
    logic [4:0] move_count;

    connect4_turn_controller #(.NO_SEL(NO_SEL)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .col_valid       (col_valid),
        .col_sel         (col_sel),
        .state           (state),
        .column_position (column_position),
        .current_player  (current_player),
        .winner          (winner),
        .invalid_move    (invalid_move),
        .move_count      (move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int inv;
        int pos;
        int st;
        int win;
        int mc;
        int pl;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Game model: brd holds 0 empty, 1 P1, 2 P2; phase 0 init, 1 play, 2 end.
    int brd[16];
    int m_phase;
    int m_player;
    int m_moves;
    int m_winner;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) brd[i] = 0;
        m_phase  = 0;
        m_player = 0;
        m_moves  = 0;
        m_winner = 0;
    endfunction

    function automatic int model_state();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 3;
        return (m_player == 1) ? 2 : 1;
    endfunction

    function automatic int height(input int col);
        int h = 0;
        for (int r = 0; r < 4; r++) if (brd[r*4 + col] != 0) h++;
        return h;
    endfunction

    function automatic bit has_four(input int p);
        bit ok;
        for (int r = 0; r < 4; r++) begin
            ok = 1;
            for (int c = 0; c < 4; c++) if (brd[r*4 + c] != p) ok = 0;
            if (ok) return 1;
        end
        for (int c = 0; c < 4; c++) begin
            ok = 1;
            for (int r = 0; r < 4; r++) if (brd[r*4 + c] != p) ok = 0;
            if (ok) return 1;
        end
        ok = 1;
        for (int i = 0; i < 4; i++) if (brd[i*4 + i] != p) ok = 0;
        if (ok) return 1;
        ok = 1;
        for (int i = 0; i < 4; i++) if (brd[i*4 + 3 - i] != p) ok = 0;
        return ok;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".state"}, int'(state), model_state());
        chk({tag, ".winner"}, int'(winner), m_winner);
        chk({tag, ".move_count"}, int'(move_count), m_moves);
        chk({tag, ".player"}, int'(current_player), m_player);
        chk({tag, ".column_position"}, int'(column_position), int'(NO_SEL));
        chk({tag, ".invalid_move"}, int'(invalid_move), 0);
    endtask

    task automatic play(input int col);
        exp_t e;
        int   h;
        int   v;
        if (m_phase == 1) begin
            h = height(col);
            if (h == 4) begin
                e = '{inv: 1, pos: 0, st: model_state(), win: m_winner, mc: m_moves,
                      pl: m_player};
            end else begin
                brd[h*4 + col] = m_player + 1;
                m_moves++;
                e.inv = 0;
                e.pos = h*4 + col;
                if (has_four(m_player + 1)) begin
                    m_winner = m_player + 1;
                    m_phase  = 2;
                end else if (m_moves == 16) begin
                    m_winner = 3;
                    m_phase  = 2;
                end else begin
                    m_player = 1 - m_player;
                end
                e.st  = model_state();
                e.win = m_winner;
                e.mc  = m_moves;
                e.pl  = m_player;
            end
            sb.push_back(e);
        end
        v = col;
        col_sel   = v[1:0];
        col_valid = 1'b1;
        @(negedge clk);
        col_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (m_phase == 0) begin
            m_phase  = 1;
            m_player = 0;
        end else if (m_phase == 2) begin
            model_reset();
        end
        @(negedge clk);
        check_outputs("start");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: consumes one expectation per position pulse or invalid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (column_position != NO_SEL || invalid_move)) begin
                if (sb.size() == 0) begin
                    chk("stray_event", int'(invalid_move) * 64 + int'(column_position),
                        int'(NO_SEL));
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", int'(invalid_move), e.inv);
                    if (e.inv == 0) chk("position", int'(column_position), e.pos);
                    @(negedge clk);
                    chk("result.state", int'(state), e.st);
                    chk("result.winner", int'(winner), e.win);
                    chk("result.move_count", int'(move_count), e.mc);
                    chk("result.player", int'(current_player), e.pl);
                    chk("result.invalid_move", int'(invalid_move), 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int seq1[7]  = '{0, 1, 0, 1, 0, 1, 0};
    int seq2[5]  = '{2, 2, 2, 2, 2};
    int seq3[16] = '{0, 2, 1, 3, 2, 0, 3, 1, 0, 2, 1, 3, 2, 0, 3, 1};
    int seq4[10] = '{0, 0, 1, 1, 3, 3, 0, 2, 1, 2};

    initial begin
        int tries;
        reset     = 1'b1;
        start     = 1'b0;
        col_valid = 1'b0;
        col_sel   = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("por");
        reset = 1'b0;
        @(negedge clk);
        check_outputs("idle");

        // Vertical P1 win in column 0
        pulse_start();
        foreach (seq1[i]) play(seq1[i]);
        check_outputs("t1");
        chk("t1.winner", int'(winner), 1);
        chk("t1.move_count", int'(move_count), 7);

        // END ignores col_valid; start -> INIT, start -> P1 turn
        play(3);
        check_outputs("t6.ignore");
        pulse_start();
        chk("t6.state_init", int'(state), 0);
        pulse_start();
        chk("t6.state_p1", int'(state), 1);

        // Full column rejected
        foreach (seq2[i]) play(seq2[i]);
        check_outputs("t2");
        chk("t2.move_count", int'(move_count), 4);
        do_reset();

        // Draw
        pulse_start();
        foreach (seq3[i]) play(seq3[i]);
        check_outputs("t3");
        chk("t3.winner", int'(winner), 3);
        chk("t3.move_count", int'(move_count), 16);

        // Horizontal P2 win on row 1
        pulse_start();
        pulse_start();
        foreach (seq4[i]) play(seq4[i]);
        check_outputs("t4");
        chk("t4.winner", int'(winner), 2);

        // Reset while the third move is in PLACE
        do_reset();
        pulse_start();
        play(0);
        play(1);
        col_sel   = 2'd0;
        col_valid = 1'b1;
        @(posedge clk);
        #2;
        reset     = 1'b1;
        col_valid = 1'b0;
        #1;
        model_reset();
        check_outputs("t5.reset_place");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        play(0);
        do_reset();

        // Random games
        for (int g = 0; g < 12; g++) begin
            pulse_start();
            tries = 0;
            while (m_phase == 1 && tries < 80) begin
                play(int'($urandom_range(0, 3)));
                tries++;
            end
            if (m_phase == 1) begin
                do_reset();
            end else begin
                play(int'($urandom_range(0, 3)));
                check_outputs("rand.end");
                pulse_start();
            end
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
